// File: rtl/mdu_pkg.sv
// mdu_pkg: op encodings, FSM state type and op-decode helpers for hilo_mdu.
// Divide support (ops DIV/DIVU) is built only when MDU_DIV_EN is defined.
package mdu_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_e;

    function automatic logic op_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic op_div(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/hilo_mdu_if.sv
// hilo_mdu_if: issue, HI/LO write and result bundle between pipeline and MDU.
// The same bundle is used whether or not MDU_DIV_EN is defined.
interface hilo_mdu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             mthi_we;
    logic             mtlo_we;
    logic [WIDTH-1:0] wd;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, flush, mthi_we, mtlo_we, wd,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush, mthi_we, mtlo_we, wd,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_iter_core.sv
// mdu_iter_core: radix-2 shift-add multiply / restoring divide datapath.
// Divide hardware exists only when MDU_DIV_EN is defined.
module mdu_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             step_i,
`ifdef MDU_DIV_EN
    input  logic             div_i,
`endif
    input  logic [WIDTH-1:0] seed_i,
    input  logic [WIDTH-1:0] opnd_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opnd_q;
    logic [WIDTH:0]   sum;
`ifdef MDU_DIV_EN
    logic             div_q;
    logic [WIDTH:0]   shl;
    logic [WIDTH:0]   diff;
`endif

    // hi:lo is the running product, or remainder:quotient when dividing
    always_comb begin
        sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        hi_d = sum[WIDTH:1];
        lo_d = {sum[0], lo_q[WIDTH-1:1]};
`ifdef MDU_DIV_EN
        shl  = {hi_q, lo_q[WIDTH-1]};
        diff = shl - {1'b0, opnd_q};
        if (div_q) begin
            hi_d = diff[WIDTH] ? shl[WIDTH-1:0] : diff[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], ~diff[WIDTH]};
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q   <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
`ifdef MDU_DIV_EN
            div_q  <= 1'b0;
`endif
        end else if (load_i) begin
            hi_q   <= '0;
            lo_q   <= seed_i;
            opnd_q <= opnd_i;
`ifdef MDU_DIV_EN
            div_q  <= div_i;
`endif
        end else if (step_i) begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;
endmodule

// File: rtl/hilo_mdu.sv
// hilo_mdu: multi-cycle MIPS-style multiply/divide unit with HI/LO registers.
// Define MDU_DIV_EN to build DIV/DIVU; otherwise those ops are ignored.
module hilo_mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic       clk,
    input logic       rst,
    hilo_mdu_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    state_e           state_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             sa_q;
    logic             sb_q;
    logic [CW-1:0]    cnt_q;
`ifdef MDU_DIV_EN
    logic             div_q;
    logic             dz_q;
`endif

    logic             sgn, is_div, op_ok, dz;
    logic             accept, step, wr_ok;
    logic             neg_a, neg_b;
    logic [WIDTH-1:0] mag_a, mag_b, seed, opnd;
    logic [WIDTH-1:0] acc_hi, acc_lo;
    logic [WIDTH-1:0] res_hi, res_lo;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        sgn    = op_signed(bus.op);
        is_div = op_div(bus.op);
        neg_a  = sgn & bus.a[WIDTH-1];
        neg_b  = sgn & bus.b[WIDTH-1];
        mag_a  = neg_a ? -bus.a : bus.a;
        mag_b  = neg_b ? -bus.b : bus.b;
`ifdef MDU_DIV_EN
        op_ok  = 1'b1;
        dz     = is_div & (bus.b == '0);
        seed   = is_div ? mag_a : mag_b;
        opnd   = is_div ? mag_b : mag_a;
`else
        op_ok  = ~is_div;
        dz     = 1'b0;
        seed   = mag_b;
        opnd   = mag_a;
`endif
        accept = (state_q == IDLE) & bus.start & ~bus.flush & op_ok;
        step   = (state_q == CALC);
        wr_ok  = (state_q == IDLE) | (state_q == DONE);
    end

    // Sign fix-up applied to the unsigned magnitude result during FIX
    always_comb begin
        prod = {acc_hi, acc_lo};
        if (sa_q ^ sb_q) prod = -prod;
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
`ifdef MDU_DIV_EN
        if (div_q) begin
            if (dz_q) begin
                res_lo = '1;
                res_hi = sa_q ? -acc_lo : acc_lo;
            end else begin
                res_lo = (sa_q ^ sb_q) ? -acc_lo : acc_lo;
                res_hi = sa_q ? -acc_hi : acc_hi;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            cnt_q   <= '0;
`ifdef MDU_DIV_EN
            div_q   <= 1'b0;
            dz_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= dz ? FIX : CALC;
                        busy_q  <= 1'b1;
                        cnt_q   <= CW'(WIDTH - 1);
                        sa_q    <= neg_a;
                        sb_q    <= neg_b;
`ifdef MDU_DIV_EN
                        div_q   <= is_div;
                        dz_q    <= dz;
`endif
                    end
                end
                CALC: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (bus.flush) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == '0) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    busy_q <= 1'b0;
                    if (bus.flush) begin
                        state_q <= IDLE;
                    end else begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        hi_q    <= res_hi;
                        lo_q    <= res_lo;
                    end
                end
                DONE: state_q <= IDLE;
            endcase
            if (wr_ok & bus.mthi_we) hi_q <= bus.wd;
            if (wr_ok & bus.mtlo_we) lo_q <= bus.wd;
        end
    end

    mdu_iter_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .load_i(accept),
        .step_i(step),
`ifdef MDU_DIV_EN
        .div_i (is_div),
`endif
        .seed_i(seed),
        .opnd_i(opnd),
        .hi_o  (acc_hi),
        .lo_o  (acc_lo)
    );

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_hilo_mdu.sv
// tb_hilo_mdu: directed and random checks of hilo_mdu against an arithmetic model.
// Divide expectations follow whether MDU_DIV_EN is defined for the build.
module tb_hilo_mdu;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hilo_mdu_if #(.WIDTH(W)) bus ();

    hilo_mdu #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;
    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;
    logic [W-1:0] corner [6];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on the architectural meaning of each op
    function automatic void model(input logic [1:0] o, input logic [W-1:0] a, b,
                                  output logic [W-1:0] eh, output logic [W-1:0] el,
                                  output int lat);
        longint sa, sb, q, r;
        longint unsigned ua, ub;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = 64'(a);
        ub  = 64'(b);
        lat = W + 2;
        p   = '0;
        case (o)
            2'b00: p = 64'(sa * sb);
            2'b01: p = ua * ub;
            default: begin
                if (b == '0) begin
                    p   = {a, {W{1'b1}}};
                    lat = 2;
                end else if (o == 2'b10) begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[W-1:0], q[W-1:0]};
                end else begin
                    p = {32'(ua % ub), 32'(ua / ub)};
                end
            end
        endcase
        eh = p[63:32];
        el = p[31:0];
    endfunction

    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a, b,
                          input bit restart, input bit wr_hi, input logic [W-1:0] whi);
        logic [W-1:0] eh, el;
        int lat, edges, busyc;
        model(o, a, b, eh, el, lat);
        bus.op      = o;
        bus.a       = a;
        bus.b       = b;
        bus.start   = 1'b1;
        bus.mthi_we = wr_hi;
        bus.wd      = whi;
        tick();
        bus.mthi_we = 1'b0;
        if (wr_hi) m_hi = whi;
`ifndef MDU_DIV_EN
        if (o[1]) begin
            bus.start = 1'b0;
            busyc = int'(bus.busy) + int'(bus.done);
            repeat (3) begin
                tick();
                busyc += int'(bus.busy) + int'(bus.done);
            end
            chk({tag, " ignored"}, busyc, 0);
            chk({tag, " hi kept"}, bus.hi, m_hi);
            chk({tag, " lo kept"}, bus.lo, m_lo);
            return;
        end
`endif
        if (wr_hi) chk({tag, " mthi at accept"}, bus.hi, whi);
        if (restart) begin
            bus.a = ~a;
            bus.b = b ^ 32'h5;
        end else begin
            bus.start = 1'b0;
        end
        edges = 1;
        busyc = (bus.busy === 1'b1) ? 1 : 0;
        while (bus.done !== 1'b1 && edges < 3 * W) begin
            tick();
            edges++;
            if (bus.busy === 1'b1) busyc++;
        end
        chk({tag, " latency"}, edges, lat);
        chk({tag, " busy cycles"}, busyc, lat - 1);
        chk({tag, " busy in done"}, bus.busy, 1'b0);
        m_hi = eh;
        m_lo = el;
        chk({tag, " hi"}, bus.hi, m_hi);
        chk({tag, " lo"}, bus.lo, m_lo);
        tick();
        chk({tag, " busy/done after"}, {bus.busy, bus.done}, 2'b00);
        bus.start = 1'b0;
    endtask

    initial begin
        int cnt;
        logic [1:0] o;
        logic [W-1:0] ra, rb;
        bit rs, wh;

        corner = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFE};
        m_hi = '0;
        m_lo = '0;
        rst  = 1'b1;
        bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
        bus.flush = 1'b0; bus.mthi_we = 1'b0; bus.mtlo_we = 1'b0; bus.wd = '0;
        #12;
        chk("reset hi", bus.hi, '0);
        chk("reset lo", bus.lo, '0);
        chk("reset busy", bus.busy, 1'b0);
        chk("reset done", bus.done, 1'b0);
        rst = 1'b0;
        tick();

        run_op("mult", 2'b00, 32'hFFFFFFFD, 32'd7, 1'b0, 1'b0, '0);
        chk("mult const", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFEB);
        run_op("multu", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, '0);
        chk("multu const", {bus.hi, bus.lo}, 64'hFFFFFFFE_00000001);
        run_op("div", 2'b10, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, '0);
        run_op("div min", 2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, '0);
        run_op("divu zero", 2'b11, 32'd5, 32'd0, 1'b1, 1'b0, '0);
        run_op("div zero neg", 2'b10, 32'hFFFFFFF9, 32'd0, 1'b0, 1'b0, '0);

        bus.mtlo_we = 1'b1;
        bus.wd = 32'hA5A5_0F0F;
        tick();
        bus.mtlo_we = 1'b0;
        m_lo = 32'hA5A5_0F0F;
        chk("mtlo idle", bus.lo, m_lo);

        run_op("mthi+accept", 2'b00, 32'd6, 32'd7, 1'b0, 1'b1, 32'hCAFEF00D);

        // Flush mid-CALC with a preloaded HI and an ignored mtlo while busy
        bus.mthi_we = 1'b1;
        bus.wd = 32'h1234;
        tick();
        bus.mthi_we = 1'b0;
        m_hi = 32'h1234;
        chk("mthi preload", bus.hi, m_hi);
        bus.op = 2'b00; bus.a = 32'd3; bus.b = 32'd4; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.mtlo_we = 1'b1;
        bus.wd = 32'hDEAD;
        tick();
        bus.mtlo_we = 1'b0;
        repeat (7) tick();
        chk("flush pre busy", bus.busy, 1'b1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush busy", bus.busy, 1'b0);
        cnt = 0;
        repeat (40) begin
            tick();
            cnt += int'(bus.done) + int'(bus.busy);
        end
        chk("flush no done", cnt, 0);
        chk("flush hi", bus.hi, m_hi);
        chk("flush lo", bus.lo, m_lo);

        bus.op = 2'b01; bus.a = 32'd5; bus.b = 32'd5;
        bus.start = 1'b1;
        bus.flush = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.flush = 1'b0;
        cnt = int'(bus.busy);
        repeat (3) begin
            tick();
            cnt += int'(bus.done) + int'(bus.busy);
        end
        chk("flush+start idle", cnt, 0);

        for (int i = 0; i < 24; i++) begin
            o  = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) ra = corner[$urandom_range(0, 5)];
            if ($urandom_range(0, 3) == 0) rb = corner[$urandom_range(0, 5)];
            if (o[1] && $urandom_range(0, 5) == 0) rb = '0;
            rs = ($urandom_range(0, 4) == 0);
            wh = ($urandom_range(0, 4) == 0);
            run_op($sformatf("rand%0d op%0d", i, o), o, ra, rb, rs, wh, $urandom);
        end

        // Asynchronous reset in the middle of an operation
        bus.op = 2'b00; bus.a = 32'h1357_9BDF; bus.b = 32'h2468_ACE0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        #2 rst = 1'b1;
        #1;
        chk("rst mid hi", bus.hi, '0);
        chk("rst mid lo", bus.lo, '0);
        chk("rst mid busy/done", {bus.busy, bus.done}, 2'b00);
        tick();
        rst = 1'b0;
        m_hi = '0;
        m_lo = '0;
        cnt = 0;
        repeat (40) begin
            tick();
            cnt += int'(bus.done) + int'(bus.busy);
        end
        chk("rst no done", cnt, 0);
        chk("rst hi kept", bus.hi, m_hi);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hilo_mdu.md
HILO_MDU -- requirements
Module: hilo_mdu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/HI/LO width; legal values are even and at least 4.
REQ-002 SHALL have port clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  in  1  issue request for op.
REQ-005 SHALL have port op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have ports a, b  in  WIDTH  operands (rs, rt).
REQ-007 SHALL have port flush  in  1  pipeline flush; aborts the in-flight op.
REQ-008 SHALL have ports mthi_we, mtlo_we  in  1  direct HI/LO writes.
REQ-009 SHALL have port wd  in  WIDTH  data for mthi/mtlo.
REQ-010 SHALL have port busy  out  1  op in flight; the pipeline stalls on mfhi/mflo/new op.
REQ-011 SHALL have port done  out  1  one-cycle completion pulse.
REQ-012 SHALL have ports hi, lo  out  WIDTH  registered HI/LO.

Function
REQ-013 SHALL use FSM states IDLE, CALC, FIX, DONE.
REQ-014 SHALL accept start only in IDLE; start while busy SHALL be ignored.
REQ-015 On accept: IDLE->CALC, latch magnitudes of a/b (signed ops) or raw a/b (unsigned ops).
REQ-016 CALC SHALL run WIDTH radix-2 iterations: shift-add for multiply, restoring shift-subtract for divide.
REQ-017 FIX SHALL last 1 cycle and apply signs: product negated if signs differ; quotient negated if signs differ; remainder takes the dividend's sign.
REQ-018 SHALL update HI/LO at the FIX->DONE edge: multiply HI=upper half, LO=lower half; divide LO=quotient, HI=remainder.
REQ-019 Latency SHALL be WIDTH+2 edges from the accept edge to the HI/LO update edge; done=1 and busy=0 for the following cycle (DONE), then DONE->IDLE.
REQ-020 busy SHALL be 1 in CALC and FIX and 0 in IDLE and DONE; a start in DONE SHALL be ignored.
REQ-021 Divide by zero SHALL skip CALC (IDLE->FIX->DONE), giving LO=all-ones and HI=a, with latency 2.
REQ-022 Signed DIV of MIN by -1 SHALL give LO=MIN and HI=0 with no exception.
REQ-023 flush in CALC/FIX SHALL return to IDLE next edge, leave HI/LO unchanged, and suppress done.
REQ-024 flush and start together in IDLE: flush SHALL win and no op is accepted.
REQ-025 mthi/mtlo SHALL write on the next edge in IDLE or DONE and be ignored while busy.
REQ-026 An mthi/mtlo write in the same cycle as a start accept SHALL take effect, and the op result SHALL later overwrite both registers.

Reset
REQ-027 rst SHALL asynchronously force state=IDLE, hi=0, lo=0, busy=0, done=0 and clear internal registers.
REQ-028 Reset mid-operation SHALL discard the op with no done pulse.

Configuration
REQ-029 With macro MDU_DIV_EN defined, divide hardware and ops 10/11 SHALL be built.
REQ-030 Without MDU_DIV_EN, ops 10/11 SHALL be ignored (no busy, no done, HI/LO unchanged) and no divide logic SHALL be built.

Structure
REQ-031 Package mdu_pkg SHALL hold the op encodings and the FSM state type.
REQ-032 Sub-module mdu_iter_core SHALL hold the shift/accumulate datapath; hilo_mdu SHALL hold the FSM, sign handling and HI/LO registers.

Verification (WIDTH=32)
REQ-033 MULT a=0xFFFFFFFD, b=7 -> after 34 edges hi=0xFFFFFFFF, lo=0xFFFFFFEB, single done pulse, busy high for exactly 33 cycles.
REQ-034 MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-035 DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-036 DIVU a=5, b=0 -> lo=0xFFFFFFFF, hi=5 after 2 edges; second start during busy ignored.
REQ-037 Preload mthi=0x1234; MULT 3*4 flushed on edge 10 -> busy=0 next cycle, no done, hi=0x1234; separately, rst asserted mid-op -> hi=lo=0 immediately.
